// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage hazard scoreboard bundle: instruction operand/destination info in,
// stall request, diagnostics and stall counter out.
interface hazard_scoreboard_unit_if #(
   parameter int unsigned REG_ADDR_W  = 4,
   parameter int unsigned STALL_CNT_W = 16
);
   logic                   with_forwarding;
   logic                   freeze;
   logic                   flush;
   logic                   issue_valid;
   logic                   ignore_hazard;
   logic                   have_two_src;
   logic [REG_ADDR_W-1:0]  src1_addr;
   logic [REG_ADDR_W-1:0]  src2_addr;
   logic                   id_wb_en;
   logic                   id_mem_read;
   logic [REG_ADDR_W-1:0]  id_dest;
   logic                   stall_cnt_clr;
   logic                   hazard_detected;
   logic                   hazard_src1;
   logic                   hazard_src2;
   logic                   busy;
   logic [STALL_CNT_W-1:0] stall_count;

   modport master (
      output with_forwarding, freeze, flush, issue_valid, ignore_hazard, have_two_src,
             src1_addr, src2_addr, id_wb_en, id_mem_read, id_dest, stall_cnt_clr,
      input  hazard_detected, hazard_src1, hazard_src2, busy, stall_count
   );

   modport slave (
      input  with_forwarding, freeze, flush, issue_valid, ignore_hazard, have_two_src,
             src1_addr, src2_addr, id_wb_en, id_mem_read, id_dest, stall_cnt_clr,
      output hazard_detected, hazard_src1, hazard_src2, busy, stall_count
   );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// RAW hazard scoreboard for the ID stage: per-register countdown of cycles until a pending
// result is consumable, zero-latency stall request and a saturating stall counter.
module hazard_scoreboard_unit #(
   parameter int unsigned REG_ADDR_W     = 4,
   parameter int unsigned WB_DIST        = 2,
   parameter int unsigned LOAD_USE_DELAY = 1,
   parameter int unsigned CNT_W          = 3,
   parameter int unsigned STALL_CNT_W    = 16
) (
   input logic                     clk,
   input logic                     rst_n,
   hazard_scoreboard_unit_if.slave bus
);
   localparam int unsigned NumRegs = 2 ** REG_ADDR_W;
   localparam logic [CNT_W-1:0] WbDist  = CNT_W'(WB_DIST);
   localparam logic [CNT_W-1:0] LoadUse = CNT_W'(LOAD_USE_DELAY);

   logic [CNT_W-1:0]       cnt_q [NumRegs];
   logic [CNT_W-1:0]       cnt_d [NumRegs];
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic                   hazard_src1, hazard_src2, hazard, issue, any_busy;
   logic [CNT_W-1:0]       load_val;

   // Squashed or operand-less instructions never request a stall.
   assign hazard_src1 = bus.issue_valid & ~bus.flush & ~bus.ignore_hazard &
                        (cnt_q[bus.src1_addr] != '0);
   assign hazard_src2 = bus.issue_valid & ~bus.flush & ~bus.ignore_hazard & bus.have_two_src &
                        (cnt_q[bus.src2_addr] != '0);
   assign hazard      = hazard_src1 | hazard_src2;
   assign issue       = bus.issue_valid & ~bus.flush & ~hazard & ~bus.freeze;

   always_comb begin
      load_val = WbDist;
      if (bus.with_forwarding) begin
         load_val = bus.id_mem_read ? LoadUse : '0;
      end
   end

   always_comb begin
      any_busy = 1'b0;
      for (int unsigned r = 0; r < NumRegs; r++) begin
         any_busy = any_busy | (cnt_q[r] != '0);
      end
   end

   always_comb begin
      for (int unsigned r = 0; r < NumRegs; r++) begin
         cnt_d[r] = cnt_q[r];
         if (!bus.freeze) begin
            if (cnt_q[r] != '0) begin
               cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
            // A fresh issue to the same register overrides the pending decrement.
            if (issue && bus.id_wb_en && (bus.id_dest == REG_ADDR_W'(r))) begin
               cnt_d[r] = load_val;
            end
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (bus.stall_cnt_clr) begin
         stall_cnt_d = '0;
      end else if (hazard && !bus.freeze && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < NumRegs; r++) begin
            cnt_q[r] <= '0;
         end
         stall_cnt_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.hazard_detected = hazard;
   assign bus.hazard_src1     = hazard_src1;
   assign bus.hazard_src2     = hazard_src2;
   assign bus.busy            = any_busy;
   assign bus.stall_count     = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed vector table, saturation and async-reset
// sequence, then random traffic against a per-register countdown model.
module tb_hazard_scoreboard_unit;
   localparam int unsigned AW = 4;
   localparam int unsigned SW = 8;
   localparam int SatMax = 255;

   typedef struct {
      bit       fwd, frz, fl, iv, ign, two, wb, mr, clr;
      bit [3:0] s1, s2, dst;
      bit       tab;
      bit       ehz, es2, ebusy;
      int       est;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_scoreboard_unit_if #(.REG_ADDR_W(AW), .STALL_CNT_W(SW)) bus ();

   hazard_scoreboard_unit #(
      .REG_ADDR_W(AW), .WB_DIST(2), .LOAD_USE_DELAY(1), .CNT_W(3), .STALL_CNT_W(SW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int nchk = 0;
   int nerr = 0;
   int cnt_m [16];
   int stall_m = 0;
   vec_t tab [$];

   function automatic vec_t mk(bit fwd, bit frz, bit fl, bit iv, bit ign, bit two,
                               int s1, int s2, bit wb, bit mr, int dst, bit clr,
                               bit ehz, bit es2, bit ebusy, int est);
      vec_t v;
      v.fwd = fwd; v.frz = frz; v.fl = fl; v.iv = iv; v.ign = ign; v.two = two;
      v.s1 = 4'(s1); v.s2 = 4'(s2); v.wb = wb; v.mr = mr; v.dst = 4'(dst); v.clr = clr;
      v.tab = 1'b1; v.ehz = ehz; v.es2 = es2; v.ebusy = ebusy; v.est = est;
      return v;
   endfunction

   function automatic vec_t idle(bit clr, bit ebusy, int est);
      return mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, clr, 0, 0, ebusy, est);
   endfunction

   task automatic check(string nm, int act, int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(vec_t v);
      bus.with_forwarding = v.fwd; bus.freeze = v.frz; bus.flush = v.fl;
      bus.issue_valid = v.iv; bus.ignore_hazard = v.ign; bus.have_two_src = v.two;
      bus.src1_addr = v.s1; bus.src2_addr = v.s2; bus.id_wb_en = v.wb;
      bus.id_mem_read = v.mr; bus.id_dest = v.dst; bus.stall_cnt_clr = v.clr;
   endtask

   task automatic model_reset();
      for (int r = 0; r < 16; r++) cnt_m[r] = 0;
      stall_m = 0;
   endtask

   // Apply one instruction slot, compare before the edge, then advance the model.
   task automatic step(vec_t v, string tag);
      bit h1, h2, hz, bsy, iss;
      drive(v);
      #2;
      h1 = v.iv && !v.fl && !v.ign && (cnt_m[v.s1] != 0);
      h2 = v.iv && !v.fl && !v.ign && v.two && (cnt_m[v.s2] != 0);
      hz = h1 || h2;
      bsy = 1'b0;
      for (int r = 0; r < 16; r++) if (cnt_m[r] != 0) bsy = 1'b1;
      check({tag, ".src1"}, int'(bus.hazard_src1), int'(h1));
      check({tag, ".src2"}, int'(bus.hazard_src2), int'(h2));
      check({tag, ".hazard"}, int'(bus.hazard_detected), int'(hz));
      check({tag, ".busy"}, int'(bus.busy), int'(bsy));
      check({tag, ".stall_count"}, int'(bus.stall_count), stall_m);
      if (v.tab) begin
         check({tag, ".exp_hazard"}, int'(bus.hazard_detected), int'(v.ehz));
         check({tag, ".exp_src2"}, int'(bus.hazard_src2), int'(v.es2));
         check({tag, ".exp_busy"}, int'(bus.busy), int'(v.ebusy));
         check({tag, ".exp_stall"}, int'(bus.stall_count), v.est);
      end
      @(posedge clk);
      if (v.clr) stall_m = 0;
      else if (hz && !v.frz && stall_m < SatMax) stall_m++;
      if (!v.frz) begin
         iss = v.iv && !v.fl && !hz;
         for (int r = 0; r < 16; r++) if (cnt_m[r] > 0) cnt_m[r]--;
         if (iss && v.wb) cnt_m[v.dst] = v.fwd ? (v.mr ? 1 : 0) : 2;
      end
      #1;
   endtask

   initial begin
      vec_t v;
      model_reset();
      drive(idle(0, 0, 0));
      // fwd: ALU producer then consumer, no stall
      tab.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // fwd: load-use, one stall
      tab.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0));
      tab.push_back(mk(1, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0, 1, 0));
      tab.push_back(mk(1, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      // no fwd: src2 consumer, two stalls
      tab.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 1));
      tab.push_back(mk(0, 0, 0, 1, 0, 1, 0, 3, 0, 0, 0, 0, 1, 1, 1, 1));
      tab.push_back(mk(0, 0, 0, 1, 0, 1, 0, 3, 0, 0, 0, 0, 1, 1, 1, 2));
      tab.push_back(mk(0, 0, 0, 1, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 3));
      // no fwd: src2 not a real operand
      tab.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 3));
      tab.push_back(mk(0, 0, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 3));
      tab.push_back(idle(0, 1, 3));
      // fwd: load then freeze for three cycles
      tab.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0, 3));
      for (int i = 0; i < 3; i++) tab.push_back(mk(1, 1, 0, 1, 0, 0, 4, 0, 0, 0, 0, 0, 1, 0, 1, 3));
      tab.push_back(mk(1, 0, 0, 1, 0, 0, 4, 0, 0, 0, 0, 0, 1, 0, 1, 3));
      tab.push_back(mk(1, 0, 0, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 4));
      // no fwd: back-to-back writes to R5 reload the countdown
      tab.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 5, 0, 0, 0, 0, 4));
      tab.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 5, 0, 0, 0, 1, 4));
      tab.push_back(idle(0, 1, 4));
      tab.push_back(idle(0, 1, 4));
      tab.push_back(idle(0, 0, 4));
      // flushed instruction neither stalls nor loads
      tab.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 6, 0, 0, 0, 0, 4));
      tab.push_back(mk(0, 0, 1, 1, 0, 0, 6, 0, 1, 0, 7, 0, 0, 0, 1, 4));
      tab.push_back(idle(0, 1, 4));
      tab.push_back(mk(0, 0, 0, 1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 4));
      // counter clear
      tab.push_back(idle(1, 0, 4));
      tab.push_back(idle(0, 0, 0));
      // stalled instruction writing its own source loads only once it issues
      tab.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 8, 0, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, 1, 0, 0, 8, 0, 1, 0, 8, 0, 1, 0, 1, 0));
      tab.push_back(mk(0, 0, 0, 1, 0, 0, 8, 0, 1, 0, 8, 0, 1, 0, 1, 1));
      tab.push_back(mk(0, 0, 0, 1, 0, 0, 8, 0, 1, 0, 8, 0, 0, 0, 0, 2));
      tab.push_back(idle(0, 1, 2));
      tab.push_back(idle(0, 1, 2));
      tab.push_back(idle(0, 0, 2));

      // Reset state
      #2;
      check("reset.hazard", int'(bus.hazard_detected), 0);
      check("reset.busy", int'(bus.busy), 0);
      check("reset.stall_count", int'(bus.stall_count), 0);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (tab[i]) step(tab[i], $sformatf("tab%0d", i));

      // Saturation: self-dependent chain stalls 2 of every 3 cycles
      step(idle(1, 0, 2), "sat_clr");
      v = mk(0, 0, 0, 1, 0, 0, 10, 0, 1, 0, 10, 0, 0, 0, 0, 0);
      v.tab = 1'b0;
      for (int i = 0; i < 421; i++) step(v, $sformatf("sat%0d", i));
      check("sat.stall_count", int'(bus.stall_count), SatMax);

      // Asynchronous reset in the middle of a stall
      drive(v);
      #2;
      check("pre_rst.hazard", int'(bus.hazard_detected), 1);
      check("pre_rst.stall_count", int'(bus.stall_count), SatMax);
      rst_n = 1'b0;
      #1;
      check("mid_rst.hazard", int'(bus.hazard_detected), 0);
      check("mid_rst.busy", int'(bus.busy), 0);
      check("mid_rst.stall_count", int'(bus.stall_count), 0);
      model_reset();
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      step(idle(0, 0, 0), "post_rst");

      // Random traffic against the model
      for (int i = 0; i < 800; i++) begin
         v.fwd = 1'($urandom_range(0, 1));
         v.frz = ($urandom_range(0, 99) < 15);
         v.fl  = ($urandom_range(0, 99) < 10);
         v.iv  = ($urandom_range(0, 99) < 90);
         v.ign = ($urandom_range(0, 99) < 20);
         v.two = 1'($urandom_range(0, 1));
         v.s1  = 4'($urandom_range(0, 7));
         v.s2  = 4'($urandom_range(0, 7));
         v.wb  = ($urandom_range(0, 99) < 70);
         v.mr  = ($urandom_range(0, 99) < 40);
         v.dst = 4'($urandom_range(0, 7));
         v.clr = ($urandom_range(0, 99) < 2);
         v.tab = 1'b0;
         step(v, $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
